// File: rtl/ifetch_queue.sv
// ifetch_queue: owns the fetch PC, issues credit-limited imem requests and queues returned instructions for decode
module ifetch_queue #(
    parameter int ISIZE = 32,
    parameter int DSIZE = 32,
    parameter logic [ISIZE-1:0] RESET_PC = 32'h0000_0000,
    parameter int QDEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_valid,
    input  logic [ISIZE-1:0] redirect_pc,
    output logic             imem_req_valid,
    output logic [ISIZE-1:0] imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_rsp_valid,
    input  logic [DSIZE-1:0] imem_rsp_data,
    output logic             dec_valid,
    output logic [DSIZE-1:0] dec_instr,
    output logic [ISIZE-1:0] dec_pc,
    input  logic             dec_ready,
    output logic [ISIZE-1:0] PCOUT
);
    localparam int AW = $clog2(QDEPTH);
    localparam int W = AW + 1;
    localparam logic [W:0] QD = (W+1)'(QDEPTH);

    logic [ISIZE-1:0] r_fetch_pc, r_rsp_pc;
    logic [W-1:0]     r_cnt, r_out, r_disc;
    logic [AW-1:0]    r_head, r_tail;
    logic [DSIZE-1:0] r_q_instr [QDEPTH];
    logic [ISIZE-1:0] r_q_pc [QDEPTH];
    logic             w_fire, w_drop, w_ret, w_push, w_pop;
    logic [ISIZE-1:0] w_redir_pc;

    // request credit, response classification and head presentation
    always_comb begin
        w_redir_pc     = redirect_pc & ~ISIZE'(3);
        imem_req_valid = rst && !redirect_valid && (({1'b0, r_cnt} + {1'b0, r_out}) < QD);
        imem_req_addr  = rst ? r_fetch_pc : RESET_PC;
        PCOUT          = imem_req_addr;
        w_fire         = imem_req_valid && imem_req_ready;
        w_drop         = imem_rsp_valid && (r_disc != '0);
        w_ret          = imem_rsp_valid && (r_disc == '0);
        w_push         = rst && w_ret && !redirect_valid;
        dec_valid      = rst && (r_cnt != '0);
        dec_instr      = r_q_instr[r_head];
        dec_pc         = r_q_pc[r_head];
        w_pop          = dec_valid && dec_ready && !redirect_valid;
    end

    // PCs, counters and queue pointers; a redirect flushes and turns in-flight requests into discards
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_cnt      <= '0;
            r_out      <= '0;
            r_disc     <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= w_redir_pc;
            r_rsp_pc   <= w_redir_pc;
            r_cnt      <= '0;
            r_out      <= '0;
            r_disc     <= r_disc - W'(w_drop) + r_out - W'(w_ret);
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            r_fetch_pc <= w_fire ? r_fetch_pc + ISIZE'(4) : r_fetch_pc;
            r_rsp_pc   <= w_push ? r_rsp_pc + ISIZE'(4) : r_rsp_pc;
            r_cnt      <= r_cnt + W'(w_push) - W'(w_pop);
            r_out      <= r_out + W'(w_fire) - W'(w_ret);
            r_disc     <= r_disc - W'(w_drop);
            r_head     <= r_head + AW'(w_pop);
            r_tail     <= r_tail + AW'(w_push);
        end
    end

    // queue storage needs no reset; count alone defines validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_tail] <= imem_rsp_data;
            r_q_pc[r_tail]    <= r_rsp_pc;
        end
    end

    assert property (@(posedge clk) disable iff (!rst) !(w_push && !w_pop && r_cnt == W'(QDEPTH)));
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: table vectors, corner sequences and a scoreboard against an in-order memory model
module tb_ifetch_queue;
    logic        clk = 0, rst = 0, redirect_valid = 0, imem_req_ready = 1, imem_rsp_valid = 0, dec_ready = 0;
    logic [31:0] redirect_pc = 0, imem_rsp_data = 0;
    logic        imem_req_valid, dec_valid;
    logic [31:0] imem_req_addr, dec_instr, dec_pc, PCOUT;
    int          n_tests = 0, n_fail = 0, cycle = 0, lat = 1, nreq = 0;
    logic [31:0] mpc = 0;

    typedef struct {logic [31:0] addr; int due;} mreq_t;
    typedef struct {logic rdy; logic rv; logic [31:0] ra; logic dv; logic [31:0] dp;} vec_t;
    mreq_t       mq[$];
    logic [31:0] sb[$];
    vec_t        vt[8];

    ifetch_queue dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_ready(dec_ready), .PCOUT(PCOUT)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] f(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic begin_cyc();
        @(posedge clk);
        #1;
        cycle++;
        imem_rsp_valid = 0;
        imem_rsp_data = 0;
        if (mq.size() > 0 && mq[0].due <= cycle) begin
            imem_rsp_valid = 1;
            imem_rsp_data = f(mq[0].addr);
            void'(mq.pop_front());
        end
    endtask

    task automatic end_cyc();
        @(negedge clk);
        if (!rst) begin
            mq.delete();
            sb.delete();
            mpc = 0;
        end else if (redirect_valid) begin
            sb.delete();
            mpc = redirect_pc & ~32'h3;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr_seq", imem_req_addr, mpc);
                mq.push_back('{imem_req_addr, cycle + lat});
                sb.push_back(mpc);
                mpc += 4;
            end
            if (dec_valid && dec_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_underflow: dec_pc %h popped with nothing expected", dec_pc);
                end else begin
                    check("sb_dec_pc", dec_pc, sb[0]);
                    check("sb_dec_instr", dec_instr, f(sb[0]));
                    void'(sb.pop_front());
                end
            end
        end
    endtask

    task automatic step(input logic rdy);
        begin_cyc();
        rst = 1;
        redirect_valid = 0;
        dec_ready = rdy;
        end_cyc();
    endtask

    task automatic redir(input logic [31:0] pc);
        begin_cyc();
        rst = 1;
        dec_ready = 1;
        redirect_valid = 1;
        redirect_pc = pc;
        end_cyc();
        check("redir_suppress", imem_req_valid, 0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            begin_cyc();
            rst = 0;
            redirect_valid = 0;
            dec_ready = 0;
            end_cyc();
            check("rst_req_valid", imem_req_valid, 0);
            check("rst_dec_valid", dec_valid, 0);
            check("rst_pcout", PCOUT, 0);
        end
    endtask

    task automatic wait_dec(input string nm, input logic [31:0] pc);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1);
            if (dec_valid) begin
                seen = 1;
                check({nm, "_first_pc"}, dec_pc, pc);
                check({nm, "_first_instr"}, dec_instr, f(pc));
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: dec_valid never rose, expected pc %h", nm, pc);
        end
    endtask

    initial begin
        vt[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
        vt[1] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
        vt[2] = '{1'b1, 1'b0, 32'h08, 1'b1, 32'h0};
        vt[3] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h4};
        vt[4] = '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h0};
        vt[5] = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h8};
        vt[6] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'hC};
        vt[7] = '{1'b1, 1'b1, 32'h14, 1'b0, 32'h0};

        lat = 1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(vt[i].rdy);
            check("t1_req_valid", imem_req_valid, vt[i].rv);
            check("t1_req_addr", imem_req_addr, vt[i].ra);
            check("t1_pcout", PCOUT, vt[i].ra);
            check("t1_dec_valid", dec_valid, vt[i].dv);
            if (vt[i].dv) begin
                check("t1_dec_pc", dec_pc, vt[i].dp);
                check("t1_dec_instr", dec_instr, f(vt[i].dp));
            end
        end

        do_reset();
        nreq = 0;
        for (int i = 0; i < 6; i++) begin
            step(0);
            if (imem_req_valid && imem_req_ready) nreq++;
        end
        check("t2_req_count", nreq, 2);
        check("t2_full_no_req", imem_req_valid, 0);
        check("t2_head_valid", dec_valid, 1);
        check("t2_head_pc", dec_pc, 32'h0);
        step(1);
        check("t2_drain0_pc", dec_pc, 32'h0);
        check("t2_drain0_no_req", imem_req_valid, 0);
        step(1);
        check("t2_drain1_pc", dec_pc, 32'h4);
        check("t2_resume_valid", imem_req_valid, 1);
        check("t2_resume_addr", imem_req_addr, 32'h8);

        do_reset();
        lat = 3;
        step(1);
        step(1);
        redir(32'h103);
        step(1);
        check("t3_req_valid", imem_req_valid, 1);
        check("t3_req_addr", imem_req_addr, 32'h100);
        check("t3_no_stale", dec_valid, 0);
        wait_dec("t3", 32'h100);

        do_reset();
        lat = 1;
        step(1);
        redir(32'h200);
        step(1);
        check("t4_not_enqueued", dec_valid, 0);
        check("t4_req_valid", imem_req_valid, 1);
        check("t4_req_addr", imem_req_addr, 32'h200);
        wait_dec("t4", 32'h200);

        do_reset();
        lat = 1;
        for (int i = 0; i < 5; i++) step(0);
        check("t5_full", dec_valid, 1);
        for (int i = 0; i < 2; i++) begin
            begin_cyc();
            rst = 0;
            dec_ready = 0;
            end_cyc();
        end
        check("t5_rst_dec_valid", dec_valid, 0);
        check("t5_rst_pcout", PCOUT, 32'h0);
        check("t5_rst_req_valid", imem_req_valid, 0);
        step(1);
        check("t5_restart_valid", imem_req_valid, 1);
        check("t5_restart_addr", imem_req_addr, 32'h0);
        check("t5_restart_empty", dec_valid, 0);
        wait_dec("t5", 32'h0);

        do_reset();
        lat = 1;
        redir(32'hFFFF_FFFC);
        step(1);
        check("t6_req_hi", imem_req_addr, 32'hFFFF_FFFC);
        check("t6_req_hi_valid", imem_req_valid, 1);
        step(1);
        check("t6_req_wrap", imem_req_addr, 32'h0);
        check("t6_req_wrap_valid", imem_req_valid, 1);
        wait_dec("t6", 32'hFFFF_FFFC);
        step(1);
        check("t6_dec_wrap_valid", dec_valid, 1);
        check("t6_dec_wrap_pc", dec_pc, 32'h0);

        do_reset();
        lat = 3;
        step(1);
        step(1);
        redir(32'h300);
        step(1);
        check("t7_req_addr", imem_req_addr, 32'h300);
        redir(32'h400);
        wait_dec("t7", 32'h400);

        do_reset();
        lat = 3;
        step(1);
        step(1);
        redir(32'h500);
        redir(32'h600);
        step(1);
        check("t8_req_addr", imem_req_addr, 32'h600);
        wait_dec("t8", 32'h600);

        do_reset();
        lat = 2;
        for (int i = 0; i < 400; i++) begin
            begin_cyc();
            rst = 1;
            dec_ready = ($urandom_range(0, 3) != 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 29) == 0);
            redirect_pc = $urandom;
            end_cyc();
        end
        imem_req_ready = 1;
        for (int i = 0; i < 10; i++) step(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
